seven_segment_driver: RTL
=========================

Name: seven_segment_driver

Overview:
Display-side counterpart of the seven-segment interface. It consumes the 8-nibble digit word plus the per-digit enable and dot masks, and time-multiplexes them onto an 8-digit common-anode display: anode scan, hex-to-segment decode and a dead-time blanking gap. Inputs are captured once per frame so the display never tears. Sits between the seven-segment interface outputs and the board's AN/SEG/DP pins.

Parameters:
REFRESH_DIV, 100000, clock cycles per digit slot; must be >= 2.
BLANK_CYCLES, 1000, cycles at the start of each slot with all anodes off; must satisfy 0 <= BLANK_CYCLES < REFRESH_DIV.

Ports:
clk  input  1  system clock; all logic on rising edge
rst  input  1  asynchronous, active-low reset
digit  input  32  nibble i = digit[4i+3:4i] is the hex value for display digit i
en_dot  input  8  bit i = 1 lights the decimal point of digit i
en_digit  input  8  bit i = 1 enables digit i; 0 keeps it dark for its whole slot
an  output  8  anode selects, active-low, one-hot-low or all ones
seg  output  7  segments {g,f,e,d,c,b,a}, active-low
dp  output  1  decimal point, active-low

Behaviour:
- Reset (rst=0, async, any time including mid-slot): an=8'hFF, seg=7'h7F, dp=1, cnt=0, idx=0, snapshot digit=32'hFFFFFFFF, snapshot en_digit=8'h00, snapshot en_dot=8'h00. Outputs stay dark until the first SHOW cycle after release.
- Slot counter cnt: 0..REFRESH_DIV-1, increments every cycle; at REFRESH_DIV-1 wraps to 0 and idx increments mod 8 (7 -> 0). Frame period = 8*REFRESH_DIV cycles.
- State is decoded from cnt: BLANK when cnt < BLANK_CYCLES, SHOW otherwise. With BLANK_CYCLES=0, BLANK never occurs.
- Snapshot: on the edge where cnt==0 and idx==0 (first cycle of each frame, including the first edge after reset release), digit/en_digit/en_dot are registered. All decode uses only the snapshot. Input changes at any other time take effect at the next frame start.
- Output registers are loaded every edge from the current cnt/idx/snapshot, giving a fixed 1-cycle lag behind slot position:
  - BLANK, or SHOW with snapshot en_digit[idx]=0: an=8'hFF, seg=7'h7F, dp=1.
  - SHOW with en_digit[idx]=1: an = ~(8'b1 << idx); seg = decode(nibble idx); dp = ~en_dot[idx].
- Decode (active-low {g..a}): 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00 9=10 A=08 b=03 C=46 d=21 E=06 F=0E (hex).
- At most one an bit is low in any cycle. Between two lit digits there are at least BLANK_CYCLES cycles with an=8'hFF. With BLANK_CYCLES=0, there is a direct one-edge switch.
- en_dot is ignored for disabled digits (dp=1).
- No handshake. Inputs are sampled only at the snapshot edge and may change freely otherwise.

Test Plan:
(All with REFRESH_DIV=4, BLANK_CYCLES=1; frame = 32 cycles.)
1. Hold rst=0, then release; separately assert rst=0 mid-SHOW of slot 5 -> an=FF, seg=7F, dp=1 immediately (async). After release: an=FF for 1 edge, then an=FE for 3 cycles.
2. digit=32'h76543210, en_digit=FF, en_dot=00 -> per slot, 1 cycle an=FF, then 3 cycles an=~(1<<i) with seg 40,79,24,30,19,12,02,78 for i=0..7; dp=1 throughout.
3. digit=32'hF0000003, en_digit=8'b10000001 -> slot 0: seg=30, an=FE; slot 7: seg=0E, an=7F; slots 1-6: an=FF for all 4 cycles.
4. en_dot=8'h04, en_digit=FF -> dp=0 only during the 3 SHOW cycles of slot 2; dp=1 during its BLANK cycle and in all other slots.
5. Change digit from 32'h00000000 to 32'hFFFFFFFF during slot 3 -> slots 3-7 of the current frame still show seg=40; the next frame shows seg=0E in all slots.
6. Run 3 frames -> idx wraps 7->0 cleanly. an=FE recurs every 32 cycles, and at no cycle is more than one an bit low.

Source files
------------

// File: rtl/seven_segment_driver.sv
// Time-multiplexed driver for an 8-digit common-anode seven-segment display.
// Inputs are captured once per frame; each digit slot opens with a dark gap.
module seven_segment_driver #(
    parameter int unsigned REFRESH_DIV  = 100000,
    parameter int unsigned BLANK_CYCLES = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] digit,
    input  logic [7:0]  en_dot,
    input  logic [7:0]  en_digit,
    output logic [7:0]  an,
    output logic [6:0]  seg,
    output logic        dp
);

    localparam int unsigned CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYCLES);

    typedef enum logic {
        PH_BLANK = 1'b0,
        PH_SHOW  = 1'b1
    } phase_e;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [31:0]      snap_digit_q;
    logic [7:0]       snap_en_q;
    logic [7:0]       snap_dot_q;
    logic [7:0]       an_q, an_d;
    logic [6:0]       seg_q, seg_d;
    logic             dp_q, dp_d;
    logic             frame_start;
    logic [3:0]       nibble;
    phase_e           phase;

    always_comb begin
        cnt_d       = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
        idx_d       = (cnt_q == CNT_LAST) ? idx_q + 3'd1 : idx_q;
        frame_start = (cnt_q == '0) && (idx_q == 3'd0);
        phase       = (cnt_q < BLANK_END) ? PH_BLANK : PH_SHOW;
        nibble      = snap_digit_q[{idx_q, 2'b00} +: 4];
    end

    // Output decode reads the pre-edge snapshot, so the frame-start edge still
    // shows the previous frame's data; new inputs appear from the next edge on.
    always_comb begin
        an_d  = '1;
        seg_d = '1;
        dp_d  = 1'b1;
        if (phase == PH_SHOW && snap_en_q[idx_q]) begin
            an_d = ~(8'b1 << idx_q);
            dp_d = ~snap_dot_q[idx_q];
            unique case (nibble)
                4'h0: seg_d = 7'h40;
                4'h1: seg_d = 7'h79;
                4'h2: seg_d = 7'h24;
                4'h3: seg_d = 7'h30;
                4'h4: seg_d = 7'h19;
                4'h5: seg_d = 7'h12;
                4'h6: seg_d = 7'h02;
                4'h7: seg_d = 7'h78;
                4'h8: seg_d = 7'h00;
                4'h9: seg_d = 7'h10;
                4'hA: seg_d = 7'h08;
                4'hB: seg_d = 7'h03;
                4'hC: seg_d = 7'h46;
                4'hD: seg_d = 7'h21;
                4'hE: seg_d = 7'h06;
                4'hF: seg_d = 7'h0E;
                default: seg_d = 7'h7F;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q        <= '0;
            idx_q        <= '0;
            snap_digit_q <= '1;
            snap_en_q    <= '0;
            snap_dot_q   <= '0;
            an_q         <= '1;
            seg_q        <= '1;
            dp_q         <= 1'b1;
        end else begin
            cnt_q <= cnt_d;
            idx_q <= idx_d;
            if (frame_start) begin
                snap_digit_q <= digit;
                snap_en_q    <= en_digit;
                snap_dot_q   <= en_dot;
            end
            an_q  <= an_d;
            seg_q <= seg_d;
            dp_q  <= dp_d;
        end
    end

    assign an  = an_q;
    assign seg = seg_q;
    assign dp  = dp_q;

endmodule
